// File: rtl/demux1x2_buf.sv
// Buffered 1-to-2 demultiplexer: each input word goes to one of two small FIFOs chosen by in_slct.
// Optional per-output push counters (cnt0/cnt1) are enabled by defining DEMUX1X2_CNT_EN.

// Handshake rule for every port pair in this file: a transfer happens on a rising clk edge
// exactly when valid && ready are both high; valid never depends on ready in the same cycle.
module demux1x2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid && pop_ready;
  assign data  = valid ? mem[rd_ptr] : '0;

  // Storage is deliberately left out of reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so plain pointer increment wraps DEPTH-1 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module demux1x2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_slct,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX1X2_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);
  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // in_ready looks only at the selected FIFO, and a full FIFO never admits a word even
  // if its consumer drains it on the same edge (no bypass).
  assign in_ready = in_slct ? !full1 : !full0;
  assign push0    = in_valid && in_ready && !in_slct;
  assign push1    = in_valid && in_ready &&  in_slct;

  demux1x2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop_ready (out0_ready),
    .full      (full0),
    .valid     (out0_valid),
    .data      (out0_data)
  );

  demux1x2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop_ready (out1_ready),
    .full      (full1),
    .valid     (out1_valid),
    .data      (out1_data)
  );

`ifdef DEMUX1X2_CNT_EN
  // Counts accepted input words per destination; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) begin
        cnt0 <= cnt0 + 16'd1;
      end
      if (push1) begin
        cnt1 <= cnt1 + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_demux1x2_buf.sv
// Bench for demux1x2_buf (WIDTH=4, DEPTH=2): directed vector table, reset/counter sequences,
// then random traffic against a queue-based reference model.
module tb_demux1x2_buf;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_slct;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
`ifdef DEMUX1X2_CNT_EN
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;
`endif

  int tests  = 0;
  int failed = 0;

  demux1x2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_slct    (in_slct),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX1X2_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Directed vector: inputs for one cycle and the outputs expected before that cycle's edge
  typedef struct {
    logic             v;
    logic             s;
    logic [WIDTH-1:0] d;
    logic             r0;
    logic             r1;
    logic             eir;
    logic             ev0;
    logic [WIDTH-1:0] ed0;
    logic             ev1;
    logic [WIDTH-1:0] ed1;
  } vec_t;

  vec_t tbl[$];

  // Scoreboard: expected contents of each output FIFO
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic s, input logic [WIDTH-1:0] d,
                     input logic r0, input logic r1, input logic eir,
                     input logic ev0, input logic [WIDTH-1:0] ed0,
                     input logic ev1, input logic [WIDTH-1:0] ed1);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r0 = r0; t.r1 = r1;
    t.eir = eir; t.ev0 = ev0; t.ed0 = ed0; t.ev1 = ev1; t.ed1 = ed1;
    tbl.push_back(t);
  endtask

  // Driver: apply inputs after the falling edge so outputs are sampled mid-cycle
  task automatic drive(input logic rst, input logic v, input logic s,
                       input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    @(negedge clk);
    rst_n = rst; in_valid = v; in_slct = s; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check_outputs(input string tag);
    logic             ev0, ev1, eir;
    logic [WIDTH-1:0] ed0, ed1;
    ev0 = (exp_q0.size() != 0);
    ev1 = (exp_q1.size() != 0);
    ed0 = ev0 ? exp_q0[0] : '0;
    ed1 = ev1 ? exp_q1[0] : '0;
    eir = in_slct ? (exp_q1.size() < DEPTH) : (exp_q0.size() < DEPTH);
    chk({tag, ".in_ready"},   32'(in_ready),   32'(eir));
    chk({tag, ".out0_valid"}, 32'(out0_valid), 32'(ev0));
    chk({tag, ".out0_data"},  32'(out0_data),  32'(ed0));
    chk({tag, ".out1_valid"}, 32'(out1_valid), 32'(ev1));
    chk({tag, ".out1_data"},  32'(out1_data),  32'(ed1));
  endtask

  // Reference model step for the upcoming edge, using pre-edge occupancies
  task automatic model_edge();
    logic push0, push1, pop0, pop1;
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      return;
    end
    pop0  = (exp_q0.size() != 0) && out0_ready;
    pop1  = (exp_q1.size() != 0) && out1_ready;
    push0 = in_valid && !in_slct && (exp_q0.size() < DEPTH);
    push1 = in_valid &&  in_slct && (exp_q1.size() < DEPTH);
    if (pop0)  void'(exp_q0.pop_front());
    if (pop1)  void'(exp_q1.pop_front());
    if (push0) exp_q0.push_back(in_data);
    if (push1) exp_q1.push_back(in_data);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_slct = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    // v  s  d     r0 r1  ir  v0 d0    v1 d1
    add(0, 0, 4'h0, 0, 0,  1,  0, 4'h0, 0, 4'h0);  // idle after reset
    add(1, 0, 4'hA, 0, 0,  1,  0, 4'h0, 0, 4'h0);  // push A -> out0
    add(0, 0, 4'h0, 1, 0,  1,  1, 4'hA, 0, 4'h0);  // A visible, popped
    add(0, 0, 4'h0, 0, 0,  1,  0, 4'h0, 0, 4'h0);
    add(1, 0, 4'h1, 0, 0,  1,  0, 4'h0, 0, 4'h0);  // push 1
    add(1, 0, 4'h2, 0, 0,  1,  1, 4'h1, 0, 4'h0);  // push 2 -> FIFO 0 full
    add(1, 0, 4'h3, 0, 0,  0,  1, 4'h1, 0, 4'h0);  // refused on full out0
    add(1, 1, 4'hF, 0, 0,  1,  1, 4'h1, 0, 4'h0);  // out1 not blocked
    add(0, 0, 4'h0, 0, 0,  0,  1, 4'h1, 1, 4'hF);
    add(0, 1, 4'h0, 0, 1,  1,  1, 4'h1, 1, 4'hF);  // drain out1
    add(1, 0, 4'h3, 1, 0,  0,  1, 4'h1, 0, 4'h0);  // no bypass while full
    add(1, 0, 4'h3, 1, 0,  1,  1, 4'h2, 0, 4'h0);  // accepted next cycle
    add(0, 0, 4'h0, 1, 0,  1,  1, 4'h3, 0, 4'h0);
    add(0, 0, 4'h0, 0, 0,  1,  0, 4'h0, 0, 4'h0);
    add(1, 0, 4'h4, 0, 0,  1,  0, 4'h0, 0, 4'h0);  // one entry
    add(1, 0, 4'h5, 1, 0,  1,  1, 4'h4, 0, 4'h0);  // push+pop rounds
    add(1, 0, 4'h6, 1, 0,  1,  1, 4'h5, 0, 4'h0);
    add(1, 0, 4'h7, 1, 0,  1,  1, 4'h6, 0, 4'h0);
    add(1, 0, 4'h8, 1, 0,  1,  1, 4'h7, 0, 4'h0);
    add(1, 0, 4'h9, 1, 0,  1,  1, 4'h8, 0, 4'h0);
    add(0, 0, 4'h0, 1, 0,  1,  1, 4'h9, 0, 4'h0);
    add(0, 0, 4'h0, 0, 0,  1,  0, 4'h0, 0, 4'h0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b1, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
      chk($sformatf("vec%0d.in_ready", i),   32'(in_ready),   32'(tbl[i].eir));
      chk($sformatf("vec%0d.out0_valid", i), 32'(out0_valid), 32'(tbl[i].ev0));
      chk($sformatf("vec%0d.out0_data", i),  32'(out0_data),  32'(tbl[i].ed0));
      chk($sformatf("vec%0d.out1_valid", i), 32'(out1_valid), 32'(tbl[i].ev1));
      chk($sformatf("vec%0d.out1_data", i),  32'(out1_data),  32'(tbl[i].ed1));
    end

    // Fill both FIFOs, then reset for one edge with consumers ready
    drive(1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("full.in_ready_s0", 32'(in_ready), 32'(0));
    drive(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("full.in_ready_s1", 32'(in_ready), 32'(0));
    drive(1'b0, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("rst.out0_valid", 32'(out0_valid), 32'(0));
    chk("rst.out0_data",  32'(out0_data),  32'(0));
    chk("rst.out1_valid", 32'(out1_valid), 32'(0));
    chk("rst.out1_data",  32'(out1_data),  32'(0));
    chk("rst.in_ready_s0", 32'(in_ready), 32'(1));
    drive(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("rst.in_ready_s1", 32'(in_ready), 32'(1));

`ifdef DEMUX1X2_CNT_EN
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("cnt.reset_cnt0", 32'(cnt0), 32'(0));
    chk("cnt.reset_cnt1", 32'(cnt1), 32'(0));
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 4'(i), 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("cnt.cnt1_after3", 32'(cnt1), 32'(3));
    chk("cnt.cnt0_after3", 32'(cnt0), 32'(0));
    // Bring cnt1 to 16'hFFFF with a continuously drained stream, then one more push
    for (int i = 3; i < 65535; i++) drive(1'b1, 1'b1, 1'b1, 4'(i), 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("cnt.cnt1_max", 32'(cnt1), 32'hFFFF);
    drive(1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("cnt.cnt1_wrap", 32'(cnt1), 32'(0));
    chk("cnt.cnt0_still0", 32'(cnt0), 32'(0));
`endif

    // Random traffic against the queue model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            WIDTH'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      check_outputs($sformatf("rnd%0d", n));
      model_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/demux1x2_buf.md
Name: demux1x2_buf

Overview:
- Buffered 1-to-2 demultiplexer with valid/ready handshakes. It is the counterpart of the 2-to-1 select mux in the utilities library.
- Routes each input word to output 0 or output 1 according to a per-word select bit. Each output has its own small FIFO.
- Used in the CPU datapath to split one producer stream between two consumers, e.g. a writeback bus shared by two units, without coupling their stall behaviour.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO. Power of two, >= 2. Pointer width is log2(DEPTH); occupancy counter width is log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  WIDTH  input word.
- in_slct  input  1  destination: 0 -> output 0, 1 -> output 1. Qualified by in_valid.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the word on the selected output.
- out0_data  output  WIDTH  head of FIFO 0.
- out0_valid  output  1  FIFO 0 not empty.
- out0_ready  input  1  consumer 0 accepts the head.
- out1_data  output  WIDTH  head of FIFO 1.
- out1_valid  output  1  FIFO 1 not empty.
- out1_ready  input  1  consumer 1 accepts the head.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Clears both FIFOs' write pointer, read pointer and count.
  - After reset: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0.
  - in_ready follows from empty FIFOs, so it is 1.
  - Storage array contents are not reset.
  - Reset mid-operation discards all buffered words. No output handshake completes on the reset edge.
- in_ready is combinational: in_slct ? !full1 : !full0. A FIFO is full when count==DEPTH.
- Push:
  - Occurs when in_valid && in_ready at a clk edge.
  - Writes in_data to mem_s[wr_ptr_s], where s=in_slct.
  - Increments wr_ptr_s, wrapping at DEPTH-1 -> 0.
- Pop on output s:
  - Occurs when outs_valid && outs_ready at a clk edge.
  - Increments rd_ptr_s with the same wrap.
- Count update, per FIFO per edge: push only -> +1; pop only -> -1; push and pop together -> unchanged; neither -> unchanged.
- Outputs:
  - outs_valid = (count_s != 0).
  - outs_data = mem_s[rd_ptr_s] when valid, else 0.
  - There is no combinational path from in_* to out*_*. Minimum latency is 1 cycle: a word pushed at edge N is visible after edge N.
- No full-bypass: when FIFO s is full, in_ready=0 even if outs_ready=1 in the same cycle.
- Empty: a pop cannot occur (valid=0); outs_ready is ignored.
- Independence: a full FIFO 1 never blocks words destined for FIFO 0. in_ready depends only on the selected FIFO.
- Word order is preserved within each output. No ordering guarantee exists between the two outputs.
- When in_valid=0, in_slct and in_data are don't-care and no push occurs.

Optional Feature:
- Macro: DEMUX1X2_CNT_EN.
- Defined:
  - Adds output ports cnt0 and cnt1, each 16 bits, after out1_ready.
  - cntS increments on every push to FIFO s (counts accepted input words, not pops).
  - Wraps 16'hFFFF -> 0.
  - Cleared to 0 by reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan (WIDTH=4, DEPTH=2):
1. Reset, then idle -> out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, in_ready=1.
2. Push 4'hA with slct=0 -> next cycle out0_valid=1, out0_data=4'hA, out1_valid=0. Pop with out0_ready=1 -> out0_valid=0.
3. With out0_ready=0, push 4'h1 and 4'h2 to output 0 -> in_ready=0 when slct=0, in_ready=1 when slct=1. Push 4'hF with slct=1 -> accepted, out1_data=4'hF.
4. FIFO 0 holds 1,2; then assert out0_ready=1 while offering 4'h3 to output 0 -> in_ready=0 on the first cycle (no bypass). The word is accepted the next cycle. Output sequence is 1,2,3.
5. FIFO 0 holds 1 entry; simultaneous push 4'h5 and pop -> count stays 1, head advances to 4'h5. Pointer wrap is exercised over 5 push/pop rounds with no corruption.
6. Fill both FIFOs, then assert rst_n=0 for one edge -> both valids 0, data 0, in_ready=1. With DEMUX1X2_CNT_EN defined: after 3 pushes to output 1, cnt1=3 and cnt0=0. Preload 16'hFFFF plus one push -> cnt1=0.
